attn_seq_ctrl: RTL and testbench

//  Parametrised sequencer for the self-attention datapath. Drives NUM_STAGES engines
//  (QKV, QK, SOFTMAX, ATTN by default) in order, once per head, for NUM_HEADS heads.

---
 rtl/attn_seq_ctrl.sv | 140 ++++++++++++++
 tb/tb_attn_seq_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/attn_seq_ctrl.sv
// attn_seq_ctrl: sequencer for the self-attention datapath.
// Launches each stage engine in order, once per head, and waits for that
// stage's completion. A per-stage watchdog, an abort input and sticky error
// reporting wrap the sequence. Every output is decoded from registered state,
// so all outputs return to zero as soon as rst is asserted.
module attn_seq_ctrl #(
    parameter int NUM_STAGES = 4,
    parameter int NUM_HEADS  = 4,
    parameter int TIMEOUT_W  = 16,
    localparam int SW = $clog2(NUM_STAGES) + 1,
    localparam int HW = $clog2(NUM_HEADS) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [TIMEOUT_W-1:0]  timeout_cycles,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic [NUM_STAGES-1:0] stage_start,
    output logic [HW-1:0]         head_idx,
    output logic [SW-1:0]         stage_idx,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [SW-1:0]         err_stage,
    output logic [HW-1:0]         err_head,
    output logic [2:0]            debug_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_DONE   = 3'd3;
    localparam logic [2:0] S_ERR    = 3'd4;

    localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES - 1);
    localparam logic [HW-1:0] LAST_HEAD  = HW'(NUM_HEADS - 1);

    logic [2:0]           state;
    logic [SW-1:0]        stage;
    logic [HW-1:0]        head;
    logic [TIMEOUT_W-1:0] timer;
    logic [TIMEOUT_W-1:0] timeout_q;
    logic [SW-1:0]        err_stage_q;
    logic [HW-1:0]        err_head_q;
    logic                 active_done;
    logic                 expire;

    // Select the completion bit of the active stage and decode the launch pulse.
    always_comb begin
        active_done = 1'b0;
        stage_start = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage == SW'(i)) begin
                active_done    = stage_done[i];
                stage_start[i] = (state == S_LAUNCH);
            end
        end
    end

    // The watchdog fires on the last allowed WAIT cycle; a zero limit disables it.
    assign expire = (timeout_q != '0) && (timer == timeout_q - TIMEOUT_W'(1));

    // Main sequencer: abort dominates, then stage completion, then the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            stage       <= '0;
            head        <= '0;
            timer       <= '0;
            timeout_q   <= '0;
            err_stage_q <= '0;
            err_head_q  <= '0;
        end else if (abort && (state != S_IDLE)) begin
            state       <= S_IDLE;
            stage       <= '0;
            head        <= '0;
            timer       <= '0;
            err_stage_q <= '0;
            err_head_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        timeout_q <= timeout_cycles;
                        head      <= '0;
                        stage     <= '0;
                        state     <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (timer != '1) begin
                        timer <= timer + TIMEOUT_W'(1);
                    end
                    if (active_done) begin
                        if (stage != LAST_STAGE) begin
                            stage <= stage + SW'(1);
                            state <= S_LAUNCH;
                        end else if (head != LAST_HEAD) begin
                            head  <= head + HW'(1);
                            stage <= '0;
                            state <= S_LAUNCH;
                        end else begin
                            state <= S_DONE;
                        end
                    end else if (expire) begin
                        err_stage_q <= stage;
                        err_head_q  <= head;
                        state       <= S_ERR;
                    end
                end
                S_DONE: begin
                    stage <= '0;
                    head  <= '0;
                    state <= S_IDLE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy        = (state == S_LAUNCH) || (state == S_WAIT);
    assign done        = (state == S_DONE);
    assign error       = (state == S_ERR);
    assign head_idx    = head;
    assign stage_idx   = stage;
    assign err_stage   = err_stage_q;
    assign err_head    = err_head_q;
    assign debug_state = state;

endmodule

// File: tb/tb_attn_seq_ctrl.sv
// tb_attn_seq_ctrl: randomized bench for attn_seq_ctrl.
// Each run is planned as a table of per-stage completion delays. The expected
// per-cycle outputs are derived from that plan by simple schedule arithmetic
// and compared against the DUT on every cycle of the run.
module tb_attn_seq_ctrl;

    localparam int NS   = 4;
    localparam int NH   = 2;
    localparam int TW   = 16;
    localparam int SW   = $clog2(NS) + 1;
    localparam int HW   = $clog2(NH) + 1;
    localparam int MAXC = 512;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic [TW-1:0] timeout_cycles;
    logic [NS-1:0] stage_done;
    logic [NS-1:0] stage_start;
    logic [HW-1:0] head_idx;
    logic [SW-1:0] stage_idx;
    logic          busy;
    logic          done;
    logic          error;
    logic [SW-1:0] err_stage;
    logic [HW-1:0] err_head;
    logic [2:0]    debug_state;

    attn_seq_ctrl #(
        .NUM_STAGES(NS),
        .NUM_HEADS (NH),
        .TIMEOUT_W (TW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .abort         (abort),
        .timeout_cycles(timeout_cycles),
        .stage_done    (stage_done),
        .stage_start   (stage_start),
        .head_idx      (head_idx),
        .stage_idx     (stage_idx),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .err_stage     (err_stage),
        .err_head      (err_head),
        .debug_state   (debug_state)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int run_id      = 0;

    // Plan: number of WAIT cycles before each stage reports completion.
    int d_plan [NH][NS];

    // Expected per-cycle outputs and stimulus hints for one run.
    int e_start [MAXC];
    int e_busy  [MAXC];
    int e_done  [MAXC];
    int e_err   [MAXC];
    int e_stage [MAXC];
    int e_head  [MAXC];
    int e_errs  [MAXC];
    int e_errh  [MAXC];
    int e_state [MAXC];
    int act     [MAXC];
    int is_launch [MAXC];
    int done_hit  [MAXC];
    int abort_at;
    int run_len;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic setPlan(input int val);
        for (int h = 0; h < NH; h++)
            for (int s = 0; s < NS; s++)
                d_plan[h][s] = val;
    endtask

    task automatic clearFrom(input int first);
        for (int c = first; c < MAXC; c++) begin
            e_start[c] = 0; e_busy[c] = 0; e_done[c] = 0; e_err[c] = 0;
            e_stage[c] = 0; e_head[c] = 0; e_errs[c] = 0; e_errh[c] = 0;
            e_state[c] = 0; act[c] = -1; is_launch[c] = 0; done_hit[c] = 0;
        end
    endtask

    // Lay out the run as a timeline: each stage occupies one launch cycle plus
    // min(delay, timeout) wait cycles; an overlong delay ends the run in error.
    task automatic buildSchedule(input int tmo, input int early);
        int  t;
        int  end_cycle;
        bit  failed;
        int  err_start;
        int  eh;
        int  es;
        int  a;
        clearFrom(0);
        t = 1; failed = 0; err_start = 0; eh = 0; es = 0;
        for (int h = 0; h < NH && !failed; h++) begin
            for (int s = 0; s < NS && !failed; s++) begin
                int  wait_len;
                bit  times_out;
                times_out = (tmo != 0) && (d_plan[h][s] > tmo);
                wait_len  = times_out ? tmo : d_plan[h][s];
                for (int k = 0; k <= wait_len; k++) begin
                    e_busy[t+k]  = 1;
                    e_stage[t+k] = s;
                    e_head[t+k]  = h;
                    e_state[t+k] = (k == 0) ? 1 : 2;
                    act[t+k]     = s;
                end
                e_start[t]   = 1 << s;
                is_launch[t] = 1;
                if (times_out) begin
                    failed    = 1;
                    err_start = t + wait_len + 1;
                    eh = h; es = s;
                end else begin
                    done_hit[t + d_plan[h][s]] = 1;
                    t = t + 1 + d_plan[h][s];
                end
            end
        end
        if (failed) begin
            end_cycle = err_start;
            abort_at  = err_start + int'($urandom_range(0, 3));
            for (int c = err_start; c <= abort_at; c++) begin
                e_err[c] = 1; e_state[c] = 4; e_errs[c] = es; e_errh[c] = eh;
            end
            run_len = abort_at + 2;
        end else begin
            end_cycle = t;
            e_done[t]  = 1;
            e_state[t] = 3;
            abort_at   = -1;
            run_len    = t + 2;
        end
        a = 0;
        if (early > 0) a = early;
        else if (early < 0 && $urandom_range(0, 3) == 0) a = int'($urandom_range(1, end_cycle - 1));
        if (a > 0 && a < end_cycle) begin
            clearFrom(a + 1);
            abort_at = a;
            run_len  = a + 2;
        end
    endtask

    task automatic checkCycle(input int c);
        string p;
        p = $sformatf("r%0d c%0d", run_id, c);
        checkOutput({p, " stage_start"}, 32'(stage_start), e_start[c]);
        checkOutput({p, " busy"},        32'(busy),        e_busy[c]);
        checkOutput({p, " done"},        32'(done),        e_done[c]);
        checkOutput({p, " error"},       32'(error),       e_err[c]);
        checkOutput({p, " debug_state"}, 32'(debug_state), e_state[c]);
        checkOutput({p, " err_stage"},   32'(err_stage),   e_errs[c]);
        checkOutput({p, " err_head"},    32'(err_head),    e_errh[c]);
        if (e_busy[c] != 0) begin
            checkOutput({p, " stage_idx"}, 32'(stage_idx), e_stage[c]);
            checkOutput({p, " head_idx"},  32'(head_idx),  e_head[c]);
        end
    endtask

    task automatic checkAllZero(input string p);
        checkOutput({p, " stage_start"}, 32'(stage_start), 0);
        checkOutput({p, " busy"},        32'(busy),        0);
        checkOutput({p, " done"},        32'(done),        0);
        checkOutput({p, " error"},       32'(error),       0);
        checkOutput({p, " debug_state"}, 32'(debug_state), 0);
        checkOutput({p, " stage_idx"},   32'(stage_idx),   0);
        checkOutput({p, " head_idx"},    32'(head_idx),    0);
        checkOutput({p, " err_stage"},   32'(err_stage),   0);
        checkOutput({p, " err_head"},    32'(err_head),    0);
    endtask

    // Drive one planned run cycle by cycle; entered and left at posedge+1.
    // Noise: inactive stage_done bits, the active bit during launch, start
    // while not idle, abort while idle and timeout_cycles after cycle 0.
    task automatic applyStimulus(input int tmo, input int early, input int rst_at);
        run_id++;
        buildSchedule(tmo, early);
        for (int c = 0; c <= run_len; c++) begin
            start          = (c == 0) || ((e_state[c] != 0) && ($urandom_range(0, 3) == 0));
            abort          = (c == abort_at) || ((e_state[c] == 0) && ($urandom_range(0, 3) == 0));
            timeout_cycles = (c == 0) ? TW'(tmo) : TW'($urandom);
            stage_done     = NS'($urandom);
            if (act[c] >= 0 && is_launch[c] == 0)
                stage_done[act[c]] = (done_hit[c] != 0);
            @(negedge clk);
            checkCycle(c);
            if (c == rst_at) begin
                #2 rst = 1'b1;
                #1 checkAllZero($sformatf("r%0d async_rst", run_id));
                @(posedge clk);
                #1 rst = 1'b0;
                start = 1'b0; abort = 1'b0; stage_done = '0;
                return;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0; abort = 1'b0; stage_done = '0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; timeout_cycles = '0; stage_done = '0;
        #1 checkAllZero("reset");
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Nominal run, each stage finishing three wait cycles after launch.
        setPlan(3);
        applyStimulus(0, 0, -1);

        // Back-to-back: completion on the first wait cycle of every stage.
        setPlan(1);
        applyStimulus(0, 0, -1);

        // Stage 2 of head 1 never completes under a five-cycle watchdog.
        setPlan(2);
        d_plan[1][2] = 100;
        applyStimulus(5, 0, -1);

        // Completion on the last allowed wait cycle, then one cycle too late.
        setPlan(1);
        d_plan[0][1] = 5;
        applyStimulus(5, 0, -1);
        d_plan[0][1] = 6;
        applyStimulus(5, 0, -1);

        // Abort during the wait of stage 1, then a clean run from head 0.
        setPlan(4);
        applyStimulus(0, 8, -1);
        setPlan(2);
        applyStimulus(0, 0, -1);

        // Asynchronous reset in the middle of a wait, then a clean run.
        setPlan(6);
        applyStimulus(0, 0, 4);
        setPlan(1);
        applyStimulus(3, 0, -1);

        // Random plans, timeouts and occasional early aborts.
        for (int r = 0; r < 25; r++) begin
            int tmo;
            for (int h = 0; h < NH; h++)
                for (int s = 0; s < NS; s++)
                    d_plan[h][s] = int'($urandom_range(1, 7));
            tmo = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(2, 8));
            applyStimulus(tmo, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
